// File: rtl/square_draw_ctrl.sv
// Control FSM for the square-drawing datapath: loads X, loads Y, then walks
// every pixel of a SIDE x SIDE square in raster order, pulsing plot per pixel.
module square_draw_ctrl #(
  parameter int SIDE = 4,
  parameter int CW   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_x,
  input  logic       go,
  output logic       ld_rxin,
  output logic       ld_ryin,
  output logic       ld_rxout,
  output logic       ld_ryout,
  output logic       selxy,
  output logic [2:0] inc,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD_X    = 4'd1;
  localparam logic [3:0] S_WAIT_X    = 4'd2;
  localparam logic [3:0] S_LOAD_Y    = 4'd3;
  localparam logic [3:0] S_CALC_X    = 4'd4;
  localparam logic [3:0] S_CALC_Y    = 4'd5;
  localparam logic [3:0] S_PLOT      = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_DONE_HOLD = 4'd8;

  localparam logic [2*CW-1:0] LAST_CNT = (2*CW)'(SIDE * SIDE - 1);

  logic [3:0]      state_reg, state_next;
  logic [2*CW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (ld_x)    state_next = S_LOAD_X;
        else if (go) state_next = S_LOAD_Y;
      end
      S_LOAD_X: state_next = S_WAIT_X;
      S_WAIT_X: if (!ld_x) state_next = S_IDLE;
      S_LOAD_Y: begin
        cnt_next   = '0;
        state_next = S_CALC_X;
      end
      S_CALC_X: state_next = S_CALC_Y;
      S_CALC_Y: state_next = S_PLOT;
      S_PLOT: begin
        if (cnt_reg == LAST_CNT) begin
          state_next = S_DONE;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          state_next = S_CALC_X;
        end
      end
      // DONE lasts exactly one cycle so the done pulse is state-decoded;
      // DONE_HOLD absorbs a go that is still held down.
      S_DONE:      state_next = go ? S_DONE_HOLD : S_IDLE;
      S_DONE_HOLD: if (!go) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ld_rxin  = 1'b0;
    ld_ryin  = 1'b0;
    ld_rxout = 1'b0;
    ld_ryout = 1'b0;
    selxy    = 1'b0;
    inc      = 3'd0;
    plot     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      S_LOAD_X: ld_rxin = 1'b1;
      S_LOAD_Y: begin
        ld_ryin = 1'b1;
        busy    = 1'b1;
      end
      S_CALC_X: begin
        ld_rxout     = 1'b1;
        inc[CW-1:0]  = cnt_reg[CW-1:0];
        busy         = 1'b1;
      end
      S_CALC_Y: begin
        ld_ryout     = 1'b1;
        selxy        = 1'b1;
        inc[CW-1:0]  = cnt_reg[2*CW-1:CW];
        busy         = 1'b1;
      end
      S_PLOT: begin
        plot = 1'b1;
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      S_DONE_HOLD: busy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_square_draw_ctrl.sv
// Bench for square_draw_ctrl: a SIDE=4 and a SIDE=2 instance checked cycle by
// cycle against a raster-order model of the expected output sequence.
module tb_square_draw_ctrl;

  logic clk;
  logic reset;
  logic ld_x, go, ld_x2, go2;
  logic ld_rxin1, ld_ryin1, ld_rxout1, ld_ryout1, selxy1, plot1, busy1, done1;
  logic [2:0] inc1;
  logic ld_rxin2, ld_ryin2, ld_rxout2, ld_ryout2, selxy2, plot2, busy2, done2;
  logic [2:0] inc2;

  int checks = 0;
  int errors = 0;

  square_draw_ctrl #(.SIDE(4), .CW(2)) dut4 (
    .clk(clk), .reset(reset), .ld_x(ld_x), .go(go),
    .ld_rxin(ld_rxin1), .ld_ryin(ld_ryin1), .ld_rxout(ld_rxout1), .ld_ryout(ld_ryout1),
    .selxy(selxy1), .inc(inc1), .plot(plot1), .busy(busy1), .done(done1)
  );

  square_draw_ctrl #(.SIDE(2), .CW(1)) dut2 (
    .clk(clk), .reset(reset), .ld_x(ld_x2), .go(go2),
    .ld_rxin(ld_rxin2), .ld_ryin(ld_ryin2), .ld_rxout(ld_rxout2), .ld_ryout(ld_ryout2),
    .selxy(selxy2), .inc(inc2), .plot(plot2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view: {ld_rxin, ld_ryin, ld_rxout, ld_ryout, selxy, inc[2:0], plot, busy, done}
  function automatic logic [10:0] mk(input logic rxin, input logic ryin, input logic rxout,
                                     input logic ryout, input logic sel, input int incv,
                                     input logic pl, input logic bs, input logic dn);
    logic [2:0] i3;
    i3 = 3'(incv);
    return {rxin, ryin, rxout, ryout, sel, i3, pl, bs, dn};
  endfunction

  function automatic logic [10:0] obs(input int sel);
    if (sel != 0)
      return {ld_rxin2, ld_ryin2, ld_rxout2, ld_ryout2, selxy2, inc2, plot2, busy2, done2};
    return {ld_rxin1, ld_ryin1, ld_rxout1, ld_ryout1, selxy1, inc1, plot1, busy1, done1};
  endfunction

  // Expected outputs k cycles after go is sampled: LOAD_Y, then per pixel
  // {x-calc, y-calc, plot} in raster order, then the done cycle.
  function automatic logic [10:0] exp_at(input int s, input int k);
    int n, j, pix, ph;
    n = s * s;
    if (k == 1) return mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
    if (k == 3 * n + 2) return mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    j   = k - 2;
    pix = j / 3;
    ph  = j % 3;
    if (ph == 0) return mk(0, 0, 1, 0, 0, pix % s, 0, 1, 0);
    if (ph == 1) return mk(0, 0, 0, 1, 1, pix / s, 0, 1, 0);
    return mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
  endfunction

  task automatic test_reset();
    logic [10:0] o;
    reset = 1'b1;
    ld_x  = 1'($urandom);
    go    = 1'($urandom);
    ld_x2 = 1'($urandom);
    go2   = 1'($urandom);
    #1;
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      checks++;
      if (o !== 11'd0) begin
        errors++;
        $display("FAIL reset_assert dut%0d got %b expected %b", d, o, 11'd0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ld_x = 0; go = 0; ld_x2 = 0; go2 = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      checks++;
      if (o !== 11'd0) begin
        errors++;
        $display("FAIL reset_release dut%0d got %b expected %b", d, o, 11'd0);
      end
    end
    $display("reset: checked both instances");
  endtask

  task automatic test_load_x(input int len);
    logic [10:0] o, e;
    @(negedge clk);
    ld_x = 1'b1;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clk);
      e = (k == 1) ? mk(1, 0, 0, 0, 0, 0, 0, 0, 0) : 11'd0;
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_x len=%0d k=%0d got %b expected %b", len, k, o, e);
      end
      if (k == len) ld_x = 1'b0;
    end
    $display("load_x: press of %0d cycles", len);
  endtask

  task automatic test_ldx_priority();
    logic [10:0] o, e;
    @(negedge clk);
    ld_x = 1'b1;
    go   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = (k == 1) ? mk(1, 0, 0, 0, 0, 0, 0, 0, 0) : 11'd0;
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ldx_priority k=%0d got %b expected %b", k, o, e);
      end
      if (k == 1) begin
        ld_x = 1'b0;
        go   = 1'b0;
      end
    end
    $display("ldx_priority: simultaneous ld_x/go");
  endtask

  task automatic run_draw(input int sel, input int hold, input int gap);
    int s, last, kmax;
    logic [10:0] o, e;
    s    = (sel != 0) ? 2 : 4;
    last = 3 * s * s + 2;
    kmax = ((hold > last) ? hold : last) + 1;
    repeat (gap + 1) @(negedge clk);
    if (sel != 0) go2 = 1'b1; else go = 1'b1;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      if (k <= last)      e = exp_at(s, k);
      else if (k <= hold) e = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      else                e = 11'd0;
      o = obs(sel);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL draw side=%0d hold=%0d k=%0d got %b expected %b", s, hold, k, o, e);
      end
      if (k == hold) begin
        if (sel != 0) go2 = 1'b0; else go = 1'b0;
      end
    end
    $display("draw: side=%0d go held %0d cycles", s, hold);
  endtask

  task automatic test_reset_middraw(input int p);
    logic [10:0] o, e;
    @(negedge clk);
    go = 1'b1;
    for (int k = 1; k <= 3 * p + 4; k++) begin
      @(negedge clk);
      e = exp_at(4, k);
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL middraw_run p=%0d k=%0d got %b expected %b", p, k, o, e);
      end
      if (k == 1) go = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    o = obs(0);
    checks++;
    if (o !== 11'd0) begin
      errors++;
      $display("FAIL middraw_async p=%0d got %b expected %b", p, o, 11'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    o = obs(0);
    checks++;
    if (o !== 11'd0) begin
      errors++;
      $display("FAIL middraw_idle p=%0d got %b expected %b", p, o, 11'd0);
    end
    $display("reset_middraw: reset at plot of pixel %0d", p);
    run_draw(0, 1, 0);
  endtask

  task automatic test_go_held();
    run_draw(0, 80, 0);
    run_draw(0, 1, 1);
  endtask

  task automatic test_random_draws();
    for (int i = 0; i < 4; i++)
      run_draw(int'($urandom_range(1, 0)), int'($urandom_range(60, 1)), int'($urandom_range(5, 0)));
  endtask

  task automatic test_side2();
    run_draw(1, 1, 0);
    run_draw(1, 20, int'($urandom_range(3, 0)));
  endtask

  initial begin
    test_reset();
    test_load_x(5);
    test_load_x(int'($urandom_range(8, 1)));
    test_ldx_priority();
    run_draw(0, 1, 0);
    test_reset_middraw(6);
    test_reset_middraw(int'($urandom_range(15, 0)));
    test_go_held();
    test_side2();
    test_random_draws();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
